// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_RESP
  } arb_state_t;

  localparam logic MEM_MODE_READ  = 1'b0;
  localparam logic MEM_MODE_WRITE = 1'b1;

  localparam int ARB_CPU_PORT = 0;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rtl/mem_arbiter_rr_picker.sv - combinational round-robin search starting at ptr
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  int idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin/lock arbiter for the single-port MEM path
// Optional: MEM_ARB_CPU_PRIORITY_EN gives port 0 absolute priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_lock,
  input  logic [NUM_REQ-1:0]             req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             ack,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           busy,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic                           mem_enable,
  output logic                           mem_mode,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  input  logic [DATA_WIDTH-1:0]          mem_rdata
);

  localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  arb_state_t              state;
  logic [PTR_W-1:0]        ptr;
  logic [PTR_W-1:0]        w_q;
  logic [PTR_W-1:0]        sel;
  logic [PTR_W-1:0]        ptr_next;
  logic                    lock_q;
  logic                    wr_q;
  logic [NUM_REQ-1:0]      pick_onehot;
  logic                    pick_valid;
  logic [NUM_REQ-1:0]      choice;
  logic                    any;
  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_onehot),
    .valid  (pick_valid)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A locked burst only continues while its owner still requests in RESP.
  always_comb begin
    choice = pick_onehot;
    any    = pick_valid;
    if (state == ARB_RESP && lock_q && req[w_q]) begin
      choice = ONE << w_q;
      any    = 1'b1;
    end
`ifdef MEM_ARB_CPU_PRIORITY_EN
    if (req[ARB_CPU_PORT]) begin
      choice = ONE << ARB_CPU_PORT;
      any    = 1'b1;
    end
`endif
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (choice[i]) sel = PTR_W'(i);
    end
    ptr_next = (sel == PTR_W'(NUM_REQ-1)) ? '0 : sel + PTR_W'(1);
  end

  assign busy = (state != ARB_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      ptr        <= '0;
      w_q        <= '0;
      lock_q     <= 1'b0;
      wr_q       <= 1'b0;
      gnt        <= '0;
      ack        <= '0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_enable <= 1'b0;
      mem_mode   <= MEM_MODE_READ;
      mem_wdata  <= '0;
    end else begin
      gnt        <= '0;
      ack        <= '0;
      mem_enable <= 1'b0;
      case (state)
        ARB_ACCESS: state <= ARB_RESP;
        default: begin
          if (state == ARB_RESP) begin
            ack <= ONE << w_q;
            if (!wr_q) rdata <= mem_rdata;
          end
          if (any) begin
            state      <= ARB_ACCESS;
            w_q        <= sel;
            lock_q     <= req_lock[sel];
            wr_q       <= req_wr[sel];
            gnt        <= choice;
            mem_enable <= 1'b1;
            mem_addr   <= addr_arr[sel];
            mem_mode   <= req_wr[sel] ? MEM_MODE_WRITE : MEM_MODE_READ;
            mem_wdata  <= wdata_arr[sel];
`ifdef MEM_ARB_CPU_PRIORITY_EN
            if (sel != PTR_W'(ARB_CPU_PORT)) ptr <= ptr_next;
`else
            ptr <= ptr_next;
`endif
          end else begin
            state <= ARB_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req, req_lock, req_wr;
  logic [47:0] req_addr;
  logic [23:0] req_wdata;
  logic [2:0]  gnt, ack;
  logic [7:0]  rdata;
  logic        busy;
  logic [15:0] mem_addr;
  logic        mem_enable, mem_mode;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem_model [0:65535];

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_lock   (req_lock),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .gnt        (gnt),
    .ack        (ack),
    .rdata      (rdata),
    .busy       (busy),
    .mem_addr   (mem_addr),
    .mem_enable (mem_enable),
    .mem_mode   (mem_mode),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory: read data appears the cycle after enable.
  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_mode) mem_model[mem_addr] <= mem_wdata;
      else          mem_rdata <= mem_model[mem_addr];
    end
  end

  typedef struct {
    int         port;
    logic       wr;
    logic [15:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic wr, input logic [15:0] addr, input logic [7:0] wd);
    req_wr[p]            = wr;
    req_addr[p*16 +: 16] = addr;
    req_wdata[p*8 +: 8]  = wd;
  endtask

  task automatic reset_dut();
    req = 3'b000;
    req_lock = 3'b000;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    req = 3'b000;
    req_lock = 3'b000;
    repeat (3) tick();
  endtask

  initial begin
    logic [2:0] oh;
    logic       prev_en;

    vecs[0] = '{1, 1'b0, 16'h1234, 8'h00, 8'hA5};
    vecs[1] = '{2, 1'b1, 16'h0010, 8'h5A, 8'hA5};
    vecs[2] = '{0, 1'b0, 16'h0010, 8'h00, 8'h5A};
    vecs[3] = '{2, 1'b1, 16'hFFFF, 8'hC3, 8'h5A};
    vecs[4] = '{1, 1'b0, 16'hFFFF, 8'h00, 8'hC3};
    vecs[5] = '{0, 1'b1, 16'hFFFF, 8'h3C, 8'hC3};
    vecs[6] = '{2, 1'b0, 16'hFFFF, 8'h00, 8'h3C};

    for (int i = 0; i < 65536; i++) mem_model[i] = 8'h00;
    mem_model[16'h1234] = 8'hA5;
    mem_rdata = 8'h00;
    req = 0; req_lock = 0; req_wr = 0; req_addr = 0; req_wdata = 0;
    rst_n = 1'b0;
    tick();
    chk("rst_gnt", {29'd0, gnt}, 0);
    chk("rst_ack", {29'd0, ack}, 0);
    chk("rst_en", {31'd0, mem_enable}, 0);
    chk("rst_mode", {31'd0, mem_mode}, 0);
    chk("rst_addr", {16'd0, mem_addr}, 0);
    chk("rst_wdata", {24'd0, mem_wdata}, 0);
    chk("rst_rdata", {24'd0, rdata}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    reset_dut();

    // Single accesses from idle, including write/read at the top address.
    for (int v = 0; v < 7; v++) begin
      oh = 3'b001 << vecs[v].port;
      set_port(vecs[v].port, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      req[vecs[v].port] = 1'b1;
      tick();
      chk($sformatf("v%0d_gnt", v), {29'd0, gnt}, {29'd0, oh});
      chk($sformatf("v%0d_en", v), {31'd0, mem_enable}, 1);
      chk($sformatf("v%0d_addr", v), {16'd0, mem_addr}, {16'd0, vecs[v].addr});
      chk($sformatf("v%0d_mode", v), {31'd0, mem_mode}, {31'd0, vecs[v].wr});
      chk($sformatf("v%0d_busy", v), {31'd0, busy}, 1);
      if (vecs[v].wr) chk($sformatf("v%0d_wdata", v), {24'd0, mem_wdata}, {24'd0, vecs[v].wdata});
      req[vecs[v].port] = 1'b0;
      tick();
      chk($sformatf("v%0d_en_off", v), {31'd0, mem_enable}, 0);
      chk($sformatf("v%0d_noack", v), {29'd0, ack}, 0);
      tick();
      chk($sformatf("v%0d_ack", v), {29'd0, ack}, {29'd0, oh});
      chk($sformatf("v%0d_rdata", v), {24'd0, rdata}, {24'd0, vecs[v].exp_rdata});
    end
    drain();

    // All three requesting continuously: strict rotation every 2 cycles.
    reset_dut();
    set_port(0, 1'b0, 16'h0000, 8'h00);
    set_port(1, 1'b0, 16'h0001, 8'h00);
    set_port(2, 1'b0, 16'h0002, 8'h00);
    req = 3'b111;
    prev_en = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c % 2 == 1) begin
        oh = 3'b001 << (((c - 1) / 2) % 3);
        chk($sformatf("rr_gnt_c%0d", c), {29'd0, gnt}, {29'd0, oh});
      end else begin
        chk($sformatf("rr_idle_c%0d", c), {29'd0, gnt}, 0);
      end
      if (c == 3) chk("rr_ack_overlap", {29'd0, ack}, 3'b001);
      chk($sformatf("rr_en_pair_c%0d", c), {31'd0, prev_en & mem_enable}, 0);
      prev_en = mem_enable;
    end
    drain();

    // Locked burst on port 2 holds off the CPU for three accesses.
    reset_dut();
    set_port(2, 1'b1, 16'h0010, 8'h5A);
    set_port(0, 1'b0, 16'h0010, 8'h00);
    req_lock[2] = 1'b1;
    req[2] = 1'b1;
    tick();
    chk("lock_g1", {29'd0, gnt}, 3'b100);
    req[0] = 1'b1;
    tick(); tick();
    chk("lock_g2", {29'd0, gnt}, 3'b100);
    tick(); tick();
    chk("lock_g3", {29'd0, gnt}, 3'b100);
    req[2] = 1'b0;
    req_lock[2] = 1'b0;
    tick(); tick();
    chk("lock_then_cpu", {29'd0, gnt}, 3'b001);
    chk("lock_last_ack", {29'd0, ack}, 3'b100);
    drain();

    // Same pattern without lock: CPU follows the first port-2 grant.
    reset_dut();
    req[2] = 1'b1;
    tick();
    chk("nolock_g1", {29'd0, gnt}, 3'b100);
    req[0] = 1'b1;
    tick(); tick();
    chk("nolock_cpu", {29'd0, gnt}, 3'b001);
    drain();

    // Lock on port 1 versus a CPU request.
    reset_dut();
    req_lock[1] = 1'b1;
    req[1] = 1'b1;
    tick();
    chk("prio_g1", {29'd0, gnt}, 3'b010);
    req[0] = 1'b1;
    tick(); tick();
`ifdef MEM_ARB_CPU_PRIORITY_EN
    chk("prio_g2", {29'd0, gnt}, 3'b001);
`else
    chk("prio_g2", {29'd0, gnt}, 3'b010);
`endif
    drain();

    // Reset asserted during RESP aborts the access; pointer returns to 0.
    reset_dut();
    set_port(1, 1'b0, 16'h1234, 8'h00);
    req[1] = 1'b1;
    tick();
    chk("rstmid_gnt", {29'd0, gnt}, 3'b010);
    req[1] = 1'b0;
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_gnt0", {29'd0, gnt}, 0);
    chk("rstmid_ack0", {29'd0, ack}, 0);
    chk("rstmid_en0", {31'd0, mem_enable}, 0);
    chk("rstmid_busy0", {31'd0, busy}, 0);
    chk("rstmid_addr0", {16'd0, mem_addr}, 0);
    chk("rstmid_rdata0", {24'd0, rdata}, 0);
    tick();
    chk("rstmid_noack_a", {29'd0, ack}, 0);
    rst_n = 1'b1;
    tick();
    chk("rstmid_noack_b", {29'd0, ack}, 0);
    req = 3'b110;
    tick();
    chk("rstmid_ptr0", {29'd0, gnt}, 3'b010);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
